// File: rtl/core_pkg.sv
// Shared constants and one-hot select helpers for the core control and dispatch blocks.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package core_pkg;

  localparam int CORE_WIDTH       = 32;
  localparam int CORE_NODES       = 5;
  localparam int CORE_RAM_LATENCY = 2;

  // Selects are zero-extended to this width before inspection.
  localparam int CORE_SEL_MAX_W = 64;
  localparam int CORE_IDX_MAX_W = 8;

  typedef logic [CORE_SEL_MAX_W-1:0] core_sel_t;
  typedef logic [CORE_IDX_MAX_W-1:0] core_idx_t;

  // Legal when exactly one bit is set and that bit lies below n.
  function automatic logic onehot_legal(input core_sel_t sel, input int n);
    int   ones;
    logic high;
    ones = 0;
    high = 1'b0;
    for (int i = 0; i < CORE_SEL_MAX_W; i++) begin
      if (sel[i]) begin
        ones++;
        if (i >= n) high = 1'b1;
      end
    end
    return (ones == 1) && !high;
  endfunction

  // Index of the set bit; only meaningful for a legal one-hot select.
  function automatic core_idx_t onehot_to_idx(input core_sel_t sel);
    core_idx_t idx;
    idx = '0;
    for (int i = 0; i < CORE_SEL_MAX_W; i++) begin
      if (sel[i]) idx = core_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/core_rd_pipe.sv
// Valid/payload delay line tracking which slot each outstanding RAM read belongs to.
// Latency: depth cycles from in_vld to out_vld.
// Backpressure: none; advances every cycle, cleared by reset.
module core_rd_pipe #(
  parameter int depth     = 3,
  parameter int payload_w = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_vld,
  input  logic [payload_w-1:0] in_dat,
  output logic                 out_vld,
  output logic [payload_w-1:0] out_dat
);

  logic [depth-1:0]     vld_q, vld_d;
  logic [payload_w-1:0] dat_q [depth];
  logic [payload_w-1:0] dat_d [depth];

  // Shift every stage by one position, new entry enters stage 0.
  always_comb begin
    vld_d[0] = in_vld;
    dat_d[0] = in_dat;
    for (int i = 1; i < depth; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Stage registers; reset drops every outstanding entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < depth; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q[depth-1];
  assign out_dat = dat_q[depth-1];

endmodule

// File: rtl/core_data_dispatcher.sv
// Issues RAM reads for one-hot node selects and scatters returned words into per-slot registers.
// Latency: slot data and node_load appear ram_latency+2 cycles after the issuing edge.
// Backpressure: none; enable only gates new issues, in-flight reads always drain.
module core_data_dispatcher #(
  parameter int width                  = core_pkg::CORE_WIDTH,
  parameter int number_of_node_in_core = core_pkg::CORE_NODES,
  parameter int ram_latency            = core_pkg::CORE_RAM_LATENCY
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic [width-1:0]                        verlet_cnt_sig,
  input  logic [width-1:0]                        ram_data_in_address,
  input  logic [width-1:0]                        ram_rd_data,
  output logic                                    ram_rd_en,
  output logic [width-1:0]                        ram_rd_addr,
  output logic [number_of_node_in_core*width-1:0] node_data,
  output logic [number_of_node_in_core-1:0]       node_load,
  output logic                                    frame_valid,
  output logic                                    sel_error
);
  import core_pkg::*;

  localparam int N     = number_of_node_in_core;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic             sel_legal;
  logic             issue;
  logic [IDX_W-1:0] issue_idx;

  logic             rd_en_q, rd_en_d;
  logic [width-1:0] rd_addr_q, rd_addr_d;
  logic             sel_error_q, sel_error_d;

  logic             pipe_vld;
  logic [IDX_W-1:0] pipe_idx;

  logic             cap_vld_q, cap_vld_d;
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic [width-1:0] cap_dat_q, cap_dat_d;

  logic [N*width-1:0] node_data_q, node_data_d;
  logic [N-1:0]       node_load_q, node_load_d;
  logic               frame_valid_q, frame_valid_d;
  logic [N-1:0]       mask_q, mask_d;
  logic [N-1:0]       mask_new;

  // Decode the select: legality check and slot index.
  always_comb begin
    sel_legal = onehot_legal(core_sel_t'(verlet_cnt_sig), N);
    issue     = enable && sel_legal;
    issue_idx = IDX_W'(onehot_to_idx(core_sel_t'(verlet_cnt_sig)));
  end

  // Read strobe/address for the RAM; address holds when nothing is issued.
  always_comb begin
    rd_en_d     = issue;
    rd_addr_d   = issue ? ram_data_in_address : rd_addr_q;
    sel_error_d = sel_error_q | (enable & ~sel_legal);
  end

  // One stage per RAM latency cycle plus the registered strobe cycle.
  core_rd_pipe #(
    .depth     (ram_latency + 1),
    .payload_w (IDX_W)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (issue),
    .in_dat  (issue_idx),
    .out_vld (pipe_vld),
    .out_dat (pipe_idx)
  );

  // Register returning RAM data together with its slot tag.
  always_comb begin
    cap_vld_d = pipe_vld;
    cap_idx_d = pipe_idx;
    cap_dat_d = pipe_vld ? ram_rd_data : cap_dat_q;
  end

  // Write the captured word into its slot and track frame completion.
  always_comb begin
    node_data_d   = node_data_q;
    node_load_d   = '0;
    frame_valid_d = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cap_vld_q && (cap_idx_q == IDX_W'(i))) begin
        node_data_d[i*width +: width] = cap_dat_q;
        node_load_d[i]                = 1'b1;
      end
    end
    mask_new = mask_q | node_load_d;
    // The last slot closes the frame whether or not every slot arrived.
    if (node_load_d[N-1]) begin
      frame_valid_d = &mask_new;
      mask_d        = '0;
    end else begin
      mask_d = mask_new;
    end
  end

  // State registers; reset overrides any same-cycle issue or capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      sel_error_q   <= 1'b0;
      cap_vld_q     <= 1'b0;
      cap_idx_q     <= '0;
      cap_dat_q     <= '0;
      node_data_q   <= '0;
      node_load_q   <= '0;
      frame_valid_q <= 1'b0;
      mask_q        <= '0;
    end else begin
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      sel_error_q   <= sel_error_d;
      cap_vld_q     <= cap_vld_d;
      cap_idx_q     <= cap_idx_d;
      cap_dat_q     <= cap_dat_d;
      node_data_q   <= node_data_d;
      node_load_q   <= node_load_d;
      frame_valid_q <= frame_valid_d;
      mask_q        <= mask_d;
    end
  end

  assign ram_rd_en   = rd_en_q;
  assign ram_rd_addr = rd_addr_q;
  assign node_data   = node_data_q;
  assign node_load   = node_load_q;
  assign frame_valid = frame_valid_q;
  assign sel_error   = sel_error_q;

endmodule

// File: doc/core_data_dispatcher.md
CORE_DATA_DISPATCHER -- requirements
Module: core_data_dispatcher

Interface
REQ-001 SHALL have parameter width, default 32, data/address word width.
REQ-002 SHALL have parameter number_of_node_in_core, default 5, node slots per core (N).
REQ-003 SHALL have parameter ram_latency, default 2, cycles from ram_rd_en high to ram_rd_data valid.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits issuing a read this cycle.
REQ-007 SHALL have port verlet_cnt_sig  input  width  one-hot node select from the core control unit; bit i selects slot i.
REQ-008 SHALL have port ram_data_in_address  input  width  RAM word address paired with verlet_cnt_sig.
REQ-009 SHALL have port ram_rd_data  input  width  RAM read data.
REQ-010 SHALL have port ram_rd_en  output  1  registered RAM read strobe.
REQ-011 SHALL have port ram_rd_addr  output  width  registered RAM read address.
REQ-012 SHALL have port node_data  output  N*width  flat slot registers; slot i at bits [i*width +: width].
REQ-013 SHALL have port node_load  output  N  one-hot pulse marking the slot updated this cycle.
REQ-014 SHALL have port frame_valid  output  1  one-cycle pulse: all N slots loaded in the current frame.
REQ-015 SHALL have port sel_error  output  1  sticky flag: illegal select seen.

Function
REQ-016 Select is legal only when exactly one of bits [N-1:0] is set and bits [width-1:N] are zero.
REQ-017 At a rising edge where enable=1 and the select is legal: ram_rd_en=1 and ram_rd_addr=ram_data_in_address during the next cycle, else ram_rd_en=0 and ram_rd_addr holds.
REQ-018 Illegal select with enable=1: no read issued; sel_error set and held until reset.
REQ-019 Issued slot index SHALL travel through a ram_latency+1 stage valid/index pipeline; ram_rd_data is captured at the edge ram_latency cycles after the ram_rd_en cycle.
REQ-020 Capture writes ram_rd_data into the addressed slot; node_data and node_load visible ram_latency+2 cycles after the sampling edge; other slots hold.
REQ-021 node_load SHALL be zero in cycles with no capture.
REQ-022 A loaded-mask records slots captured since the last frame boundary; a repeated slot overwrites data, no error.
REQ-023 On capture of slot N-1: frame_valid=1 in the same cycle as node_load[N-1] iff mask including slot N-1 is all ones; mask clears in either case (partial frame is discarded silently).
REQ-024 enable=0 SHALL not stall in-flight reads; the pipeline drains and the mask is retained.
REQ-025 Back-to-back issue every cycle SHALL be sustained with no bubbles: one frame_valid per N issue cycles.

Reset
REQ-026 On reset: ram_rd_en=0, ram_rd_addr=0, node_data=0, node_load=0, frame_valid=0, sel_error=0, mask and pipeline cleared.
REQ-027 Reads in flight at reset SHALL be discarded; data returning afterwards is ignored.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-029 Shared package core_pkg SHALL hold default width, node count, ram_latency and the one-hot-to-index and one-hot-legality functions used by control and dispatch blocks.
REQ-030 The valid/index delay line SHALL be a sub-module core_rd_pipe (parameter depth, payload width).

Verification (width=32, N=5, ram_latency=2; RAM model returns 3*addr)
REQ-031 Reset, enable=1, sel 1,2,4,8,16 with addr 1,6,11,16,21 on consecutive edges 0..4 -> slots = 3,18,33,48,63; node_load 1..16 in cycles after edges 4..8; frame_valid single pulse in cycle after edge 8.
REQ-032 verlet_cnt_sig=3 (and separately 0, and 32) with enable=1 -> ram_rd_en stays 0, sel_error=1 and held until reset.
REQ-033 Reset asserted after two loads of a frame -> all outputs 0 next cycle, returning data ignored; following full frame -> exactly one frame_valid.
REQ-034 enable=0 for 3 cycles after slot 2 issued -> in-flight slots still load; remaining slots issued after resume; frame_valid on slot 4 load.
REQ-035 After reset start at sel=4 through 16 -> slots 2..4 load, no frame_valid; next full frame -> frame_valid.
REQ-036 Three continuous frames -> frame_valid every 5 cycles, no gaps in node_load.
